// File: rtl/pid_rate_gate.sv
// pid_rate_gate
// Edge-detects the Electron/Muon/Pion flags from the trigger TDC, counts each
// over a programmable gate window and latches the per-window totals for
// local-bus readout. Also issues a one-cycle trigger pulse with a type code,
// filtered by a per-type mask and a post-pulse hold-off.
// Optional feature: define PID_PRESCALE_EN to add a trigger prescaler at
// register BASE_ADDR+6 (otherwise that address reads 0 and ignores writes).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | disabled; live counters held at 0, waiting for EN
// S_COUNT | window open; rises counted, gate counter running down
// S_LATCH | one cycle; live totals copied to readout, next window armed
module pid_rate_gate #(
  parameter logic [7:0]  BASE_ADDR    = 8'hD0,
  parameter logic [31:0] GATE_DEFAULT = 32'd1000,
  parameter logic [7:0]  HOLDOFF      = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Electron,
  input  logic        Muon,
  input  logic        Pion,
  input  logic [31:0] DataIn,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] DataOut,
  output logic        TrigOut,
  output logic [1:0]  TrigType
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]       r_ctrl;
  logic [31:0]      r_gate;
  logic [31:0]      r_gate_cnt;
  logic [2:0]       r_flag_q;
  logic [2:0][23:0] r_live;
  logic [2:0]       r_live_ovf;
  logic [2:0][23:0] r_lat;
  logic [2:0]       r_lat_ovf;
  logic [15:0]      r_win_num;
  logic             r_win_valid;
  logic [7:0]       r_hold;

  logic [7:0]  w_off;
  logic        w_in_range;
  logic        w_wr_ctrl;
  logic        w_wr_gate;
  logic        w_en;
  logic [2:0]  w_mask;
  logic [2:0]  w_rise;
  logic [2:0]  w_qual;
  logic [31:0] w_gate_load;
  logic        w_cand;
  logic        w_fire;
  logic [1:0]  w_type;
  logic [31:0] w_psc_rd;

  // Offset arithmetic wraps, so a single compare covers the 7-register range.
  assign w_off       = Address - BASE_ADDR;
  assign w_in_range  = (w_off < 8'd7);
  assign w_wr_ctrl   = Write && (w_off == 8'd0);
  assign w_wr_gate   = Write && (w_off == 8'd1);
  assign w_en        = r_ctrl[0];
  assign w_mask      = r_ctrl[3:1];
  assign w_rise      = {Pion, Muon, Electron} & ~r_flag_q;
  assign w_gate_load = (r_gate == 32'd0) ? 32'd1 : r_gate;
  assign w_qual      = w_rise & w_mask &
                       {3{(r_state == S_COUNT) || (r_state == S_LATCH)}};
  // A candidate is a masked-in rise outside the hold-off of the last pulse.
  assign w_cand      = (|w_qual) && (r_hold == 8'd0);

  // Trigger type priority: electron > muon > pion.
  always_comb begin
    w_type = 2'b00;
    if (w_qual[0])      w_type = 2'b01;
    else if (w_qual[1]) w_type = 2'b10;
    else if (w_qual[2]) w_type = 2'b11;
  end

`ifdef PID_PRESCALE_EN
  logic [15:0] r_prescale;
  logic [15:0] r_psc_cnt;
  logic        w_wr_psc;

  assign w_wr_psc = Write && (w_off == 8'd6);
  assign w_fire   = w_cand && (r_psc_cnt == r_prescale);
  assign w_psc_rd = {16'h0, r_prescale};

  // Prescale register and counter; every (N+1)th candidate is passed on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= 16'd0;
      r_psc_cnt  <= 16'd0;
    end else if (w_wr_psc) begin
      r_prescale <= DataIn[15:0];
      r_psc_cnt  <= 16'd0;
    end else if (w_cand) begin
      r_psc_cnt <= (r_psc_cnt == r_prescale) ? 16'd0 : r_psc_cnt + 16'd1;
    end
  end
`else
  assign w_fire   = w_cand;
  assign w_psc_rd = 32'h0;
`endif

  // Configuration registers written from the local bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= 4'd0;
      r_gate <= GATE_DEFAULT;
    end else begin
      if (w_wr_ctrl) r_ctrl <= DataIn[3:0];
      if (w_wr_gate) r_gate <= DataIn;
    end
  end

  // One-cycle history of the flags for rise detection.
  always_ff @(posedge clk) begin
    if (rst) r_flag_q <= 3'b000;
    else     r_flag_q <= {Pion, Muon, Electron};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; losing EN during a window abandons it without a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_en) w_state_nxt = S_COUNT;
      S_COUNT: begin
        if (!w_en)                    w_state_nxt = S_IDLE;
        else if (r_gate_cnt <= 32'd1) w_state_nxt = S_LATCH;
      end
      S_LATCH: w_state_nxt = w_en ? S_COUNT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Window datapath: gate counter, live counters and latched totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_cnt  <= 32'd0;
      r_live      <= '0;
      r_live_ovf  <= 3'b000;
      r_lat       <= '0;
      r_lat_ovf   <= 3'b000;
      r_win_num   <= 16'd0;
      r_win_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_live     <= '0;
          r_live_ovf <= 3'b000;
          if (w_en) r_gate_cnt <= w_gate_load;
        end
        S_COUNT: begin
          if (!w_en) begin
            r_live     <= '0;
            r_live_ovf <= 3'b000;
          end else begin
            r_gate_cnt <= r_gate_cnt - 32'd1;
            for (int i = 0; i < 3; i++) begin
              if (w_rise[i]) begin
                if (r_live[i] == 24'hFFFFFF) r_live_ovf[i] <= 1'b1;
                else                         r_live[i]     <= r_live[i] + 24'd1;
              end
            end
          end
        end
        S_LATCH: begin
          r_lat       <= r_live;
          r_lat_ovf   <= r_live_ovf;
          r_win_num   <= r_win_num + 16'd1;
          r_win_valid <= 1'b1;
          r_gate_cnt  <= w_gate_load;
          r_live_ovf  <= 3'b000;
          // A rise during LATCH belongs to the window that opens next.
          for (int i = 0; i < 3; i++) begin
            r_live[i] <= {23'd0, w_rise[i] & w_en};
          end
        end
        default: begin
          r_live     <= '0;
          r_live_ovf <= 3'b000;
        end
      endcase
    end
  end

  // Registered trigger pulse and hold-off counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      TrigOut  <= 1'b0;
      TrigType <= 2'b00;
      r_hold   <= 8'd0;
    end else begin
      TrigOut  <= w_fire;
      TrigType <= w_fire ? w_type : 2'b00;
      if (w_fire)              r_hold <= HOLDOFF;
      else if (r_hold != 8'd0) r_hold <= r_hold - 8'd1;
    end
  end

  // Combinational readout; zero unless addressed, so it can be OR-combined.
  always_comb begin
    DataOut = 32'h0;
    if (Read && w_in_range) begin
      case (w_off)
        8'd0:    DataOut = {28'h0, r_ctrl};
        8'd1:    DataOut = r_gate;
        8'd2:    DataOut = {r_lat_ovf[0], 7'h0, r_lat[0]};
        8'd3:    DataOut = {r_lat_ovf[1], 7'h0, r_lat[1]};
        8'd4:    DataOut = {r_lat_ovf[2], 7'h0, r_lat[2]};
        8'd5:    DataOut = {15'h0, r_win_valid, r_win_num};
        8'd6:    DataOut = w_psc_rd;
        default: DataOut = 32'h0;
      endcase
    end
  end

endmodule
